// File: rtl/enemy_laser_scheduler_pkg.sv
// Shared types and default timing for the enemy laser scheduler.
package enemy_laser_scheduler_pkg;

   // Per-channel lifecycle of one enemy laser.
   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_WARN = 2'd1,
      CH_FIRE = 2'd2,
      CH_COOL = 2'd3
   } ch_state_e;

   localparam int unsigned CNT_W          = 8;
   localparam int unsigned DEF_N_ENEMY    = 8;
   localparam int unsigned DEF_WARN_TICKS = 4;
   localparam int unsigned DEF_FIRE_TICKS = 6;
   localparam int unsigned DEF_COOL_TICKS = 3;
   localparam int unsigned DEF_MAX_ACTIVE = 3;

   // WARN and FIRE are the states that count against the active limit.
   function automatic logic is_busy(input ch_state_e s);
      return (s == CH_WARN) || (s == CH_FIRE);
   endfunction

endpackage

// File: rtl/enemy_laser_scheduler_if.sv
// Game-side control and per-channel display/collision signals of the scheduler.
interface enemy_laser_scheduler_if
   import enemy_laser_scheduler_pkg::*;
#(
   parameter int unsigned N_ENEMY = DEF_N_ENEMY
);
   localparam int unsigned IW = $clog2(N_ENEMY);
   localparam int unsigned AW = $clog2(N_ENEMY + 1);

   logic                game_run;
   logic                tick;
   logic                fire_req;
   logic [IW-1:0]       rand_idx;
   logic [N_ENEMY-1:0]  enemy_enable;
   logic [N_ENEMY-1:0]  enemy_warning_enable;
   logic [N_ENEMY-1:0]  enemy_laser_enable;
   logic [AW-1:0]       active_count;
   logic                launch_ack;
   logic                launch_reject;

   modport master (
      output game_run, tick, fire_req, rand_idx, enemy_enable,
      input  enemy_warning_enable, enemy_laser_enable, active_count,
             launch_ack, launch_reject
   );

   modport slave (
      input  game_run, tick, fire_req, rand_idx, enemy_enable,
      output enemy_warning_enable, enemy_laser_enable, active_count,
             launch_ack, launch_reject
   );

endinterface

// File: rtl/enemy_laser_scheduler_laser_channel.sv
// One enemy laser channel: IDLE -> WARN -> FIRE -> COOL -> IDLE on game ticks.
module laser_channel
   import enemy_laser_scheduler_pkg::*;
#(
   parameter int unsigned WARN_TICKS = DEF_WARN_TICKS,
   parameter int unsigned FIRE_TICKS = DEF_FIRE_TICKS,
   parameter int unsigned COOL_TICKS = DEF_COOL_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic game_run_i,
   input  logic tick_i,
   input  logic launch_i,
   input  logic enemy_en_i,
   output logic warn_o,
   output logic laser_o,
   output logic idle_o_c,
   output logic busy_next_o_c
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             warn_q, warn_d;
   logic             laser_q, laser_d;

   // State, counter and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         warn_q  <= 1'b0;
         laser_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         warn_q  <= warn_d;
         laser_q <= laser_d;
      end
   end

   // Next state: stop > launch > enemy lost > tick countdown; a launch is never ticked.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!game_run_i) begin
         state_d = CH_IDLE;
         cnt_d   = '0;
      end else if (launch_i) begin
         state_d = CH_WARN;
         cnt_d   = CNT_W'(WARN_TICKS);
      end else if (is_busy(state_q) && !enemy_en_i) begin
         state_d = CH_IDLE;
         cnt_d   = '0;
      end else if (tick_i && (state_q != CH_IDLE)) begin
         if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            case (state_q)
               CH_WARN: begin
                  state_d = CH_FIRE;
                  cnt_d   = CNT_W'(FIRE_TICKS);
               end
               CH_FIRE: begin
                  if (COOL_TICKS == 0) begin
                     state_d = CH_IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = CH_COOL;
                     cnt_d   = CNT_W'(COOL_TICKS);
                  end
               end
               default: begin
                  state_d = CH_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
      warn_d  = (state_d == CH_WARN);
      laser_d = (state_d == CH_FIRE);
   end

   assign warn_o        = warn_q;
   assign laser_o       = laser_q;
   assign idle_o_c      = (state_q == CH_IDLE);
   assign busy_next_o_c = is_busy(state_d);

endmodule

// File: rtl/enemy_laser_scheduler.sv
// Launch arbitration and active-channel accounting over N_ENEMY laser channels.
module enemy_laser_scheduler
   import enemy_laser_scheduler_pkg::*;
#(
   parameter int unsigned N_ENEMY    = DEF_N_ENEMY,
   parameter int unsigned WARN_TICKS = DEF_WARN_TICKS,
   parameter int unsigned FIRE_TICKS = DEF_FIRE_TICKS,
   parameter int unsigned COOL_TICKS = DEF_COOL_TICKS,
   parameter int unsigned MAX_ACTIVE = DEF_MAX_ACTIVE
) (
   input  logic                     clk,
   input  logic                     rst,
   enemy_laser_scheduler_if.slave   bus
);

   localparam int unsigned AW = $clog2(N_ENEMY + 1);

   logic [N_ENEMY-1:0] warn_v, laser_v, idle_v, busy_next_v, launch_v;
   logic               idx_ok, accept;
   logic [AW-1:0]      count_q, count_d;
   logic               ack_q, ack_d;
   logic               rej_q, rej_d;

   // Result pulses and post-edge active count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         ack_q   <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ack_q   <= ack_d;
         rej_q   <= rej_d;
      end
   end

   // Accept a request only for a live, idle, in-range channel while under the active limit.
   always_comb begin
      idx_ok = (32'(bus.rand_idx) < N_ENEMY);
      accept = bus.game_run && bus.fire_req && idx_ok &&
               idle_v[bus.rand_idx] && bus.enemy_enable[bus.rand_idx] &&
               (count_q < AW'(MAX_ACTIVE));
      launch_v = accept ? (N_ENEMY'(1) << bus.rand_idx) : '0;
      ack_d    = accept;
      rej_d    = bus.fire_req && !accept;
      count_d  = '0;
      for (int i = 0; i < int'(N_ENEMY); i++) begin
         count_d = count_d + AW'(busy_next_v[i]);
      end
   end

   // Independent per-channel timers.
   for (genvar g = 0; g < int'(N_ENEMY); g++) begin : g_ch
      laser_channel #(
         .WARN_TICKS (WARN_TICKS),
         .FIRE_TICKS (FIRE_TICKS),
         .COOL_TICKS (COOL_TICKS)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .game_run_i    (bus.game_run),
         .tick_i        (bus.tick),
         .launch_i      (launch_v[g]),
         .enemy_en_i    (bus.enemy_enable[g]),
         .warn_o        (warn_v[g]),
         .laser_o       (laser_v[g]),
         .idle_o_c      (idle_v[g]),
         .busy_next_o_c (busy_next_v[g])
      );
   end

   assign bus.enemy_warning_enable = warn_v;
   assign bus.enemy_laser_enable   = laser_v;
   assign bus.active_count         = count_q;
   assign bus.launch_ack           = ack_q;
   assign bus.launch_reject        = rej_q;

endmodule

// File: tb/tb_enemy_laser_scheduler.sv
// Bench: default-parameter scheduler plus a 5-channel, no-cooldown variant on shared stimulus.
module tb_enemy_laser_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       game_run, tick, fire_req;
   logic [2:0] rand_idx;
   logic [7:0] en;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   enemy_laser_scheduler_if #(.N_ENEMY(8)) b0 ();
   enemy_laser_scheduler_if #(.N_ENEMY(5)) b1 ();

   assign b0.game_run     = game_run;
   assign b0.tick         = tick;
   assign b0.fire_req     = fire_req;
   assign b0.rand_idx     = rand_idx;
   assign b0.enemy_enable = en;
   assign b1.game_run     = game_run;
   assign b1.tick         = tick;
   assign b1.fire_req     = fire_req;
   assign b1.rand_idx     = rand_idx;
   assign b1.enemy_enable = en[4:0];

   enemy_laser_scheduler u_dut0 (.clk(clk), .rst(rst), .bus(b0));

   enemy_laser_scheduler #(
      .N_ENEMY(5), .WARN_TICKS(2), .FIRE_TICKS(3), .COOL_TICKS(0), .MAX_ACTIVE(2)
   ) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   // Reference model: each channel is "ticks elapsed since launch" (-1 = idle).
   int pn[2] = '{8, 5};
   int pw[2] = '{4, 2};
   int pf[2] = '{6, 3};
   int pc[2] = '{3, 0};
   int pm[2] = '{3, 2};
   int el[2][8];
   bit exp_ack[2];
   bit exp_rej[2];

   function automatic int phase(input int k, input int e);
      if (e < 0) return 0;
      if (e < pw[k]) return 1;
      if (e < pw[k] + pf[k]) return 2;
      return 3;
   endfunction

   function automatic logic [31:0] exp_vec(input int k, input int ph);
      logic [31:0] v = '0;
      for (int i = 0; i < pn[k]; i++) if (phase(k, el[k][i]) == ph) v[i] = 1'b1;
      return v;
   endfunction

   function automatic int exp_count(input int k);
      int c = 0;
      for (int i = 0; i < pn[k]; i++) if (phase(k, el[k][i]) inside {1, 2}) c++;
      return c;
   endfunction

   task automatic model_step(input int k);
      bit acc;
      int p;
      if (rst) begin
         for (int i = 0; i < 8; i++) el[k][i] = -1;
         exp_ack[k] = 1'b0;
         exp_rej[k] = 1'b0;
         return;
      end
      acc = game_run && fire_req && (int'(rand_idx) < pn[k]) && (el[k][rand_idx] < 0) &&
            en[rand_idx] && (exp_count(k) < pm[k]);
      exp_ack[k] = acc;
      exp_rej[k] = fire_req && !acc;
      if (!game_run) begin
         for (int i = 0; i < 8; i++) el[k][i] = -1;
      end else begin
         for (int i = 0; i < pn[k]; i++) begin
            if (el[k][i] >= 0) begin
               p = phase(k, el[k][i]);
               if ((p == 1 || p == 2) && !en[i]) el[k][i] = -1;
               else if (tick) begin
                  el[k][i]++;
                  if (el[k][i] >= pw[k] + pf[k] + pc[k]) el[k][i] = -1;
               end
            end
         end
         if (acc) el[k][rand_idx] = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("d0.warn",   32'(b0.enemy_warning_enable), exp_vec(0, 1));
      chk("d0.laser",  32'(b0.enemy_laser_enable),   exp_vec(0, 2));
      chk("d0.count",  32'(b0.active_count),         32'(exp_count(0)));
      chk("d0.ack",    32'(b0.launch_ack),           32'(exp_ack[0]));
      chk("d0.reject", 32'(b0.launch_reject),        32'(exp_rej[0]));
      chk("d1.warn",   32'(b1.enemy_warning_enable), exp_vec(1, 1));
      chk("d1.laser",  32'(b1.enemy_laser_enable),   exp_vec(1, 2));
      chk("d1.count",  32'(b1.active_count),         32'(exp_count(1)));
      chk("d1.ack",    32'(b1.launch_ack),           32'(exp_ack[1]));
      chk("d1.reject", 32'(b1.launch_reject),        32'(exp_rej[1]));
   endtask

   // One clock: model consumes the inputs seen at the edge, then outputs are compared.
   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   task automatic drive(input bit gr, input bit tk, input bit fr, input logic [2:0] idx);
      game_run = gr;
      tick     = tk;
      fire_req = fr;
      rand_idx = idx;
   endtask

   typedef struct {
      bit         gr, tk, fr;
      logic [2:0] idx;
      logic [7:0] e, w, l;
      logic [3:0] c;
      bit         a, r;
   } vec_t;

   function automatic vec_t mk(input bit gr, tk, fr, input logic [2:0] idx,
                               input logic [7:0] e, w, l, input logic [3:0] c,
                               input bit a, r);
      vec_t v;
      v.gr = gr; v.tk = tk; v.fr = fr; v.idx = idx; v.e = e;
      v.w = w; v.l = l; v.c = c; v.a = a; v.r = r;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[$];
      int   nw;

      rst = 1'b1;
      en  = 8'hFF;
      drive(0, 0, 0, 3'd0);
      repeat (2) cycle();
      chk("reset.count", 32'(b0.active_count), 32'd0);
      rst = 1'b0;

      // Single launch on channel 2 through its full lifecycle (defaults).
      tv.push_back(mk(1,0,1,3'd2,8'hFF,8'h04,8'h00,4'd1,1,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h04,8'h00,4'd1,0,0));
      tv.push_back(mk(1,0,1,3'd2,8'hFF,8'h04,8'h00,4'd1,0,1));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h04,8'h00,4'd1,0,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h04,8'h00,4'd1,0,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h04,4'd1,0,0));
      for (int i = 0; i < 5; i++) tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h04,4'd1,0,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h00,4'd0,0,0));
      tv.push_back(mk(1,0,1,3'd2,8'hFF,8'h00,8'h00,4'd0,0,1));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h00,4'd0,0,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h00,4'd0,0,0));
      tv.push_back(mk(1,1,0,3'd0,8'hFF,8'h00,8'h00,4'd0,0,0));
      tv.push_back(mk(1,0,1,3'd2,8'hFF,8'h04,8'h00,4'd1,1,0));
      tv.push_back(mk(0,0,1,3'd2,8'hFF,8'h00,8'h00,4'd0,0,1));
      tv.push_back(mk(1,0,1,3'd5,8'hDF,8'h00,8'h00,4'd0,0,1));
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].gr, tv[i].tk, tv[i].fr, tv[i].idx);
         en = tv[i].e;
         cycle();
         chk($sformatf("tbl%0d.warn", i),  32'(b0.enemy_warning_enable), 32'(tv[i].w));
         chk($sformatf("tbl%0d.laser", i), 32'(b0.enemy_laser_enable),   32'(tv[i].l));
         chk($sformatf("tbl%0d.count", i), 32'(b0.active_count),         32'(tv[i].c));
         chk($sformatf("tbl%0d.ack", i),   32'(b0.launch_ack),           32'(tv[i].a));
         chk($sformatf("tbl%0d.rej", i),   32'(b0.launch_reject),        32'(tv[i].r));
      end

      // Launch coinciding with a tick still gets all warning ticks.
      en = 8'hFF;
      drive(1, 1, 1, 3'd1);
      cycle();
      nw = 0;
      while (b0.enemy_warning_enable[1] && nw < 20) begin
         drive(1, 1, 0, 3'd0);
         cycle();
         nw++;
      end
      chk("same_cycle_tick.warn_ticks", 32'(nw), 32'd4);
      repeat (12) cycle();
      chk("same_cycle_tick.idle", 32'(b0.active_count), 32'd0);

      // Active limit: fourth launch rejected until a slot frees.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 3'(i));
         cycle();
      end
      drive(1, 0, 1, 3'd3);
      cycle();
      chk("limit.reject", 32'(b0.launch_reject), 32'd1);
      chk("limit.count",  32'(b0.active_count),  32'd3);
      drive(1, 1, 0, 3'd0);
      repeat (10) cycle();
      drive(1, 0, 1, 3'd3);
      cycle();
      chk("limit.ack_after_cool", 32'(b0.launch_ack), 32'd1);
      drive(1, 1, 0, 3'd0);
      repeat (14) cycle();

      // Enemy dies while firing: laser drops, slot frees, relaunch allowed.
      drive(1, 0, 1, 3'd4);
      cycle();
      drive(1, 1, 0, 3'd0);
      repeat (5) cycle();
      chk("kill.laser_on", 32'(b0.enemy_laser_enable[4]), 32'd1);
      drive(1, 0, 0, 3'd0);
      en = 8'hEF;
      cycle();
      chk("kill.laser_off", 32'(b0.enemy_laser_enable[4]), 32'd0);
      chk("kill.count",     32'(b0.active_count),          32'd0);
      en = 8'hFF;
      drive(1, 0, 1, 3'd4);
      cycle();
      chk("kill.relaunch", 32'(b0.launch_ack), 32'd1);

      // Asynchronous reset mid-cycle, then game stop.
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 3'(i));
         cycle();
      end
      drive(1, 0, 0, 3'd0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst.warn",  32'(b0.enemy_warning_enable), 32'd0);
      chk("async_rst.laser", 32'(b0.enemy_laser_enable),   32'd0);
      chk("async_rst.count", 32'(b0.active_count),         32'd0);
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 3'(i));
         cycle();
      end
      drive(0, 0, 0, 3'd0);
      cycle();
      chk("stop.warn",  32'(b0.enemy_warning_enable), 32'd0);
      chk("stop.count", 32'(b0.active_count),         32'd0);

      // Random play against the model.
      for (int n = 0; n < 4000; n++) begin
         drive($urandom_range(99) != 0, $urandom_range(2) == 0,
               1'($urandom_range(1)), 3'($urandom_range(7)));
         if ($urandom_range(9) == 0) en[$urandom_range(7)] ^= 1'b1;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/enemy_laser_scheduler.md
ENEMY_LASER_SCHEDULER -- requirements
Module: enemy_laser_scheduler

Interface
REQ-001 SHALL have parameter N_ENEMY, default 8: number of enemy laser channels, 2..32.
REQ-002 SHALL have parameter WARN_TICKS, default 4: ticks spent in warning, 1..255.
REQ-003 SHALL have parameter FIRE_TICKS, default 6: ticks the laser is on, 1..255.
REQ-004 SHALL have parameter COOL_TICKS, default 3: ticks a channel rests after firing, 0..255.
REQ-005 SHALL have parameter MAX_ACTIVE, default 3: maximum channels in WARN or FIRE at once, 1..N_ENEMY.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port game_run, input, 1: high while play is in progress; low clears all channels.
REQ-009 SHALL have port tick, input, 1: one-clk game-frame pulse that advances all timers.
REQ-010 SHALL have port fire_req, input, 1: one-clk request to launch on channel rand_idx.
REQ-011 SHALL have port rand_idx, input, IW = clog2(N_ENEMY): candidate channel.
REQ-012 SHALL have port enemy_enable, input, N_ENEMY: enemy alive per channel.
REQ-013 SHALL have port enemy_warning_enable, output, N_ENEMY: warning graphic per channel.
REQ-014 SHALL have port enemy_laser_enable, output, N_ENEMY: laser beam per channel (collision source).
REQ-015 SHALL have port active_count, output, clog2(N_ENEMY+1): number of channels in WARN or FIRE.
REQ-016 SHALL have port launch_ack and launch_reject, outputs, 1 each: one-clk result pulses for fire_req.

Function
REQ-017 Each channel SHALL run an FSM IDLE -> WARN -> FIRE -> COOL -> IDLE with an 8-bit tick down-counter.
REQ-018 enemy_warning_enable[i] SHALL be high exactly while channel i is in WARN; enemy_laser_enable[i] exactly while in FIRE; both registered.
REQ-019 fire_req SHALL be accepted iff game_run=1, rand_idx < N_ENEMY, channel rand_idx is IDLE, enemy_enable[rand_idx]=1, and active_count < MAX_ACTIVE.
REQ-020 Accepted fire_req SHALL move the channel to WARN with counter=WARN_TICKS on the next edge; warning visible 1 clk after fire_req; launch_ack pulses in that same cycle.
REQ-021 Rejected fire_req SHALL leave all state unchanged and pulse launch_reject 1 clk later.
REQ-022 On tick, each non-IDLE channel SHALL decrement its counter; at counter=1 it SHALL advance: WARN->FIRE (load FIRE_TICKS), FIRE->COOL (load COOL_TICKS), COOL->IDLE.
REQ-023 COOL_TICKS=0 SHALL make FIRE->IDLE directly.
REQ-024 A channel entering WARN in the same cycle as tick SHALL NOT be decremented by that tick.
REQ-025 Ticks with no active channel and clocks without tick SHALL change nothing.
REQ-026 enemy_enable[i] falling while channel i is in WARN or FIRE SHALL send it to IDLE on the next edge (no cooldown); in COOL it SHALL complete normally.
REQ-027 game_run=0 SHALL force every channel to IDLE, outputs 0, on the next edge; fire_req ignored (rejected).
REQ-028 active_count SHALL be registered and reflect post-edge channel states; it SHALL never exceed MAX_ACTIVE.
REQ-029 Only one launch per clk; all channels SHALL time independently and concurrently.

Reset
REQ-030 rst=1 SHALL asynchronously force all channels IDLE, counters 0, all outputs 0, active_count 0.
REQ-031 rst released mid-frame SHALL resume on the first clk edge with rst=0; no pending request retained.

Structure
REQ-032 Shared package SHALL hold the channel state enum (IDLE, WARN, FIRE, COOL) and default timing constants.
REQ-033 Per-channel FSM+counter SHALL be sub-module laser_channel, instantiated N_ENEMY times by generate; launch arbitration and active_count stay in the top.

Verification
REQ-034 Defaults, enemy_enable=8'hFF, fire_req idx 2 -> warning[2] high next clk for 4 ticks, laser[2] for 6 ticks, then 3 ticks COOL, then idle; launch_ack once.
REQ-035 Launch idx 0,1,2 then idx 3 -> idx 3 gets launch_reject, active_count=3; after channel 0 reaches COOL, idx 3 accepted.
REQ-036 fire_req idx 5 with enemy_enable[5]=0, or idx 5 already in COOL -> launch_reject, no output change.
REQ-037 Channel 4 in FIRE, enemy_enable[4] drops -> laser[4]=0 next clk, active_count decrements, channel 4 relaunchable immediately once re-enabled.
REQ-038 fire_req and tick same cycle -> channel still shows exactly WARN_TICKS full ticks of warning.
REQ-039 Three channels busy, assert rst mid-clock -> all outputs 0 immediately; game_run=0 -> same on next edge.
